lcd_bus_arbiter: RTL and testbench
==================================

Name: lcd_bus_arbiter

Overview:
- Shares the 8-bit 8080-style LCD write bus (lcd_data, lcd_rs, lcd_wr) between two requesters.
  - Requester 0: command/init sequencer, fixed high priority.
  - Requester 1: pixel streamer.
- Arbitrates per packet, generates lcd_wr strobe timing and, optionally, aligns pixel frames to the panel tearing signal lcd_fmark.
- Sits between the requesters and the chip-level LCD pins, clocked by the SB_HFOSC-derived clk.

Parameters:
- WR_LOW_CYCLES, 2, cycles lcd_wr is held low per beat (>=1).
- WR_HIGH_CYCLES, 2, cycles lcd_wr is held high after each beat before the next accept (>=1).
- FMARK_SYNC, 1, 1 = a requester-1 packet flagged r1_frame waits for an lcd_fmark rising edge; 0 = ignore fmark.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- r0_valid  in  1  requester 0 beat valid
- r0_ready  out  1  requester 0 beat accepted when valid&ready
- r0_rs  in  1  beat register-select (0 = command, 1 = data)
- r0_data  in  8  beat byte
- r0_last  in  1  final beat of packet
- r1_valid  in  1  requester 1 beat valid
- r1_ready  out  1  requester 1 accept
- r1_rs  in  1  beat register-select
- r1_data  in  8  beat byte
- r1_last  in  1  final beat of packet
- r1_frame  in  1  first beat of a frame; sampled with r1_valid at arbitration
- lcd_data  out  8  LCD bus data
- lcd_rs  out  1  LCD register select
- lcd_wr  out  1  LCD write strobe, active low; LCD samples on rising edge
- lcd_fmark  in  1  asynchronous tearing-effect input
- grant  out  2  one-hot current owner
- busy  out  1  high when state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: lcd_wr=1, lcd_rs=0, lcd_data=0, grant=0, r0_ready=r1_ready=0, busy=0, state=IDLE, counters=0.
- lcd_fmark: passes through a 2-flop synchronizer. A rising edge is a registered sync value of 0 followed by 1.
- State IDLE (no grant, lcd_wr=1):
  - r0_valid wins over r1_valid.
  - On a winner, grant is registered next cycle.
  - Next state is READY, or WAIT_FMARK if the winner is r1, r1_frame=1 and FMARK_SYNC=1.
- State WAIT_FMARK (grant=2'b10, ready=0, lcd_wr=1):
  - Goes to READY on the first synchronized rising edge detected while in this state.
  - Edges before entry do not count. fmark already high at entry means waiting for the next edge.
  - No timeout.
- State READY:
  - rX_ready = grant[X]. This is a function of state and grant only, never of valid.
  - On valid&ready at cycle T, rs and data are latched.
  - At T+1: lcd_data and lcd_rs take the new values, lcd_wr=0, state WR_LOW.
- State WR_LOW: lcd_wr=0 for exactly WR_LOW_CYCLES cycles, then WR_HIGH.
- State WR_HIGH:
  - lcd_wr=1 for WR_HIGH_CYCLES cycles.
  - Then IDLE with grant cleared if the latched beat had last=1, else READY.
- Beat throughput:
  - Next accept is at earliest T+WR_LOW_CYCLES+WR_HIGH_CYCLES+1.
  - Default throughput is 1 beat / 5 cycles.
- lcd_data and lcd_rs hold their values from the launch of a beat until the next beat launches, including through idle periods.
- No preemption: grant is held from the first beat through the last=1 beat.
  - Valid dropping mid-packet leaves the arbiter in READY with lcd_wr=1 indefinitely.
- After a packet completes, IDLE re-arbitrates with r0 priority, so r0 packets can interleave between r1 packets.
- rX_last is only meaningful on accepted beats.
- Reset mid-operation:
  - Takes effect next edge and forces all reset values; lcd_wr returns high immediately.
  - A beat already accepted is considered consumed and is not replayed.
  - The partial packet is abandoned and the grant is released.

Test Plan:
- Single r0 beat (rs=0, data=0x2C, last=1), defaults:
  - grant=01 one cycle after valid, r0_ready high in READY.
  - lcd_data=0x2C and lcd_rs=0 with lcd_wr low exactly 2 cycles.
  - busy clears and grant=00 after the 2 high cycles.
- r0_valid and r1_valid both asserted in IDLE, r0 packet of 3 beats:
  - r0 is granted and 3 lcd_wr pulses are issued 5 cycles apart.
  - Then r1 is granted; r1_ready stays 0 throughout the r0 packet.
- r0_valid rising mid-way through a 4-beat r1 packet: all 4 r1 beats complete first, with no r0_ready; r0 is granted next.
- FMARK_SYNC=1, r1_frame=1, lcd_fmark low for 100 cycles:
  - Stays in WAIT_FMARK with lcd_wr=1 and r1_ready=0.
  - fmark rises, then r1_ready asserts within 4 cycles.
- lcd_fmark already high when WAIT_FMARK is entered: no release until fmark goes low, then high again.
- rst asserted during the WR_LOW of beat 2 of a 3-beat packet:
  - Next cycle lcd_wr=1, grant=00, busy=0, lcd_data=0.
  - A fresh r1 packet after reset starts with beat 1 of the new packet.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Purpose: shares the 8080-style LCD write bus between a high-priority command
//          requester (r0) and a pixel streamer (r1), arbitrating per packet and
//          generating the lcd_wr strobe; optional frame alignment to lcd_fmark.
// Latency: grant one cycle after valid in IDLE; a beat accepted at T drives the
//          bus at T+1, and the next accept is at earliest T+WR_LOW+WR_HIGH+1.
// Backpressure: rX_ready depends only on state and grant, never on valid.
//          Dropping valid mid-packet parks the arbiter in READY.
// Ports:   clk/rst (sync, active high); r0_*/r1_* valid-ready beat inputs;
//          lcd_data/lcd_rs/lcd_wr bus outputs; lcd_fmark async tearing input;
//          grant (one-hot owner), busy (state != IDLE).
module lcd_bus_arbiter #(
    parameter int WR_LOW_CYCLES  = 2,
    parameter int WR_HIGH_CYCLES = 2,
    parameter int FMARK_SYNC     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic       r0_rs,
    input  logic [7:0] r0_data,
    input  logic       r0_last,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic       r1_rs,
    input  logic [7:0] r1_data,
    input  logic       r1_last,
    input  logic       r1_frame,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_wr,
    input  logic       lcd_fmark,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int CMAX = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int CW   = (CMAX < 2) ? 1 : $clog2(CMAX);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FMARK = 3'd1,
        READY      = 3'd2,
        WR_LOW     = 3'd3,
        WR_HIGH    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          rs_q, rs_d;
    logic          last_q, last_d;
    logic          armed_q, armed_d;
    logic          fm_s1_q, fm_s2_q;

    // Ready is purely a function of registered state and owner.
    assign r0_ready = (state_q == READY) && grant_q[0];
    assign r1_ready = (state_q == READY) && grant_q[1];
    assign lcd_wr   = (state_q != WR_LOW);
    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
        last_d  = last_q;
        armed_d = armed_q;
        case (state_q)
            IDLE: begin
                armed_d = 1'b0;
                if (r0_valid) begin
                    grant_d = 2'b01;
                    state_d = READY;
                end else if (r1_valid) begin
                    grant_d = 2'b10;
                    state_d = ((FMARK_SYNC != 0) && r1_frame) ? WAIT_FMARK : READY;
                end
            end
            WAIT_FMARK: begin
                // Only a low-then-high seen while waiting counts as an edge, so
                // an fmark that is already high at entry must drop first.
                if (!fm_s2_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (r0_ready && r0_valid) begin
                    data_d  = r0_data;
                    rs_d    = r0_rs;
                    last_d  = r0_last;
                    cnt_d   = '0;
                    state_d = WR_LOW;
                end else if (r1_ready && r1_valid) begin
                    data_d  = r1_data;
                    rs_d    = r1_rs;
                    last_d  = r1_last;
                    cnt_d   = '0;
                    state_d = WR_LOW;
                end
            end
            WR_LOW: begin
                if (cnt_q == CW'(WR_LOW_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WR_HIGH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WR_HIGH: begin
                if (cnt_q == CW'(WR_HIGH_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (last_q) begin
                        grant_d = 2'b00;
                        state_d = IDLE;
                    end else begin
                        state_d = READY;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            last_q  <= 1'b0;
            armed_q <= 1'b0;
            fm_s1_q <= 1'b0;
            fm_s2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            last_q  <= last_d;
            armed_q <= armed_d;
            fm_s1_q <= lcd_fmark;
            fm_s2_q <= fm_s1_q;
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Purpose: self-checking bench for lcd_bus_arbiter: directed scenarios plus a
//          randomized packet mix checked against per-requester ordered models.
// Latency: drives inputs at posedge+1, samples outputs at posedge+1/+2.
// Backpressure: requester models hold a beat until valid&ready is seen.
module tb_lcd_bus_arbiter;

    localparam int LOW  = 2;
    localparam int HIGH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_valid, r0_ready, r0_rs, r0_last;
    logic [7:0] r0_data;
    logic       r1_valid, r1_ready, r1_rs, r1_last, r1_frame;
    logic [7:0] r1_data;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_wr, lcd_fmark, busy;
    logic [1:0] grant;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .WR_LOW_CYCLES (LOW),
        .WR_HIGH_CYCLES(HIGH),
        .FMARK_SYNC    (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .r0_valid (r0_valid),
        .r0_ready (r0_ready),
        .r0_rs    (r0_rs),
        .r0_data  (r0_data),
        .r0_last  (r0_last),
        .r1_valid (r1_valid),
        .r1_ready (r1_ready),
        .r1_rs    (r1_rs),
        .r1_data  (r1_data),
        .r1_last  (r1_last),
        .r1_frame (r1_frame),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_wr   (lcd_wr),
        .lcd_fmark(lcd_fmark),
        .grant    (grant),
        .busy     (busy)
    );

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic       last;
        logic       frame;
    } beat_t;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t r0_q[$];
    beat_t r1_q[$];
    beat_t exp0[$];
    beat_t exp1[$];
    logic [8:0] want[$];
    bit    p0 = 1'b0;
    bit    p1 = 1'b0;

    // Bus monitor: every completed strobe (wr low->high) is one LCD write.
    logic [8:0] cap_q[$];
    int         low_q[$];
    int         fall_q[$];
    logic       prev_wr = 1'b1;
    int         low_run = 0;
    int         mon_cyc = 0;

    always @(posedge clk) begin
        #2;
        mon_cyc = mon_cyc + 1;
        if (prev_wr === 1'b1 && lcd_wr === 1'b0) begin
            fall_q.push_back(mon_cyc);
            low_run = 0;
        end
        if (lcd_wr === 1'b0) low_run = low_run + 1;
        if (prev_wr === 1'b0 && lcd_wr === 1'b1) begin
            low_q.push_back(low_run);
            cap_q.push_back({lcd_rs, lcd_data});
        end
        prev_wr = lcd_wr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic rs, input logic [7:0] d, input logic last,
                                 input logic frame);
        beat_t b;
        b.rs = rs; b.data = d; b.last = last; b.frame = frame;
        return b;
    endfunction

    task automatic drive();
        beat_t b;
        b = '0;
        if (r0_q.size() > 0) b = r0_q[0];
        r0_valid = (r0_q.size() > 0) && !p0;
        r0_rs = b.rs; r0_data = b.data; r0_last = b.last;
        b = '0;
        if (r1_q.size() > 0) b = r1_q[0];
        r1_valid = (r1_q.size() > 0) && !p1;
        r1_rs = b.rs; r1_data = b.data; r1_last = b.last; r1_frame = b.frame;
    endtask

    task automatic tick();
        bit f0, f1;
        @(negedge clk);
        f0 = r0_valid && r0_ready;
        f1 = r1_valid && r1_ready;
        @(posedge clk);
        #1;
        if (f0 && r0_q.size() > 0) void'(r0_q.pop_front());
        if (f1 && r1_q.size() > 0) void'(r1_q.pop_front());
        drive();
    endtask

    task automatic push_pkt(input int req, input int len, input logic [7:0] base,
                            input logic rs, input logic frame);
        for (int i = 0; i < len; i++) begin
            if (req == 0) r0_q.push_back(mk(rs, base + 8'(i), (i == len - 1), 1'b0));
            else          r1_q.push_back(mk(rs, base + 8'(i), (i == len - 1), frame && (i == 0)));
            want.push_back({rs, base + 8'(i)});
        end
    endtask

    task automatic run_idle(input int bound, output int v0, output int v1, output bit to);
        int n;
        n = 0; v0 = 0; v1 = 0; to = 1'b0;
        while ((r0_q.size() > 0 || r1_q.size() > 0 || busy) && !to) begin
            tick();
            n++;
            if (r0_q.size() > 0 && r1_ready) v1++;
            if (r1_q.size() > 0 && r0_ready) v0++;
            if (n >= bound) to = 1'b1;
        end
    endtask

    task automatic cmp_cap(input string tag, input int mark);
        chk({tag, "_count"}, 32'(cap_q.size() - mark), 32'(want.size()));
        for (int i = 0; i < want.size(); i++)
            if (mark + i < cap_q.size()) chk({tag, "_beat"}, 32'(cap_q[mark + i]), 32'(want[i]));
        want.delete();
    endtask

    initial begin
        int  mark, fm, n, v, v0, v1, bad, owner, npk, len, req;
        bit  to;
        beat_t e;
        logic [8:0] c;

        rst = 1'b1;
        lcd_fmark = 1'b0;
        drive();
        repeat (3) tick();
        chk("rst_wr", 32'(lcd_wr), 32'd1);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_r0_ready", 32'(r0_ready), 32'd0);
        chk("rst_r1_ready", 32'(r1_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single r0 beat, exact strobe timing.
        mark = cap_q.size();
        push_pkt(0, 1, 8'h2C, 1'b0, 1'b0);
        drive();
        tick();
        chk("t1_grant", 32'(grant), 32'b01);
        chk("t1_r0_ready", 32'(r0_ready), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_wr_pre", 32'(lcd_wr), 32'd1);
        tick();
        chk("t1_wr_low1", 32'(lcd_wr), 32'd0);
        chk("t1_data", 32'(lcd_data), 32'h2C);
        chk("t1_rs", 32'(lcd_rs), 32'd0);
        tick();
        chk("t1_wr_low2", 32'(lcd_wr), 32'd0);
        tick();
        chk("t1_wr_high1", 32'(lcd_wr), 32'd1);
        chk("t1_busy_high1", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_high2", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_done", 32'(busy), 32'd0);
        chk("t1_grant_done", 32'(grant), 32'd0);
        chk("t1_data_hold", 32'(lcd_data), 32'h2C);
        cmp_cap("t1", mark);

        // Both valid in IDLE: r0 3-beat packet first, then r1.
        mark = cap_q.size();
        fm = fall_q.size();
        push_pkt(0, 3, 8'h01, 1'b0, 1'b0);
        push_pkt(1, 2, 8'h81, 1'b1, 1'b0);
        drive();
        tick();
        chk("t2_grant_r0", 32'(grant), 32'b01);
        run_idle(200, v0, v1, to);
        chk("t2_timeout", 32'(to), 32'd0);
        chk("t2_r1_ready_during_r0", 32'(v1), 32'd0);
        cmp_cap("t2", mark);
        if (fall_q.size() >= fm + 3) begin
            chk("t2_gap1", 32'(fall_q[fm + 1] - fall_q[fm]), 32'(LOW + HIGH + 1));
            chk("t2_gap2", 32'(fall_q[fm + 2] - fall_q[fm + 1]), 32'(LOW + HIGH + 1));
        end

        // r0 arrives mid-way through a 4-beat r1 packet: no preemption.
        mark = cap_q.size();
        push_pkt(1, 4, 8'h90, 1'b1, 1'b0);
        drive();
        n = 0;
        while (r1_q.size() != 3 && n < 50) begin tick(); n++; end
        push_pkt(0, 1, 8'h20, 1'b0, 1'b0);
        drive();
        run_idle(200, v0, v1, to);
        chk("t3_timeout", 32'(to), 32'd0);
        chk("t3_r0_ready_during_r1", 32'(v0), 32'd0);
        cmp_cap("t3", mark);

        // Frame beat waits for an fmark rising edge.
        mark = cap_q.size();
        push_pkt(1, 1, 8'hA5, 1'b1, 1'b1);
        drive();
        tick();
        tick();
        v = 0;
        repeat (100) begin
            tick();
            if (r1_ready !== 1'b0 || lcd_wr !== 1'b1 || grant !== 2'b10) v++;
        end
        chk("t4_wait_viol", 32'(v), 32'd0);
        chk("t4_busy_wait", 32'(busy), 32'd1);
        lcd_fmark = 1'b1;
        n = 0;
        while (!r1_ready && n < 10) begin tick(); n++; end
        chk("t4_released", 32'(r1_ready), 32'd1);
        chk("t4_latency_le4", 32'(n <= 4), 32'd1);
        run_idle(100, v0, v1, to);
        chk("t4_timeout", 32'(to), 32'd0);
        cmp_cap("t4", mark);

        // fmark already high at entry: needs low then high.
        mark = cap_q.size();
        push_pkt(1, 1, 8'hB6, 1'b1, 1'b1);
        drive();
        v = 0;
        repeat (20) begin tick(); if (r1_ready) v++; end
        lcd_fmark = 1'b0;
        repeat (6) begin tick(); if (r1_ready) v++; end
        chk("t5_early_release", 32'(v), 32'd0);
        chk("t5_grant_wait", 32'(grant), 32'b10);
        lcd_fmark = 1'b1;
        n = 0;
        while (!r1_ready && n < 10) begin tick(); n++; end
        chk("t5_released", 32'(r1_ready), 32'd1);
        chk("t5_latency_le4", 32'(n <= 4), 32'd1);
        run_idle(100, v0, v1, to);
        cmp_cap("t5", mark);

        // Reset during WR_LOW of beat 2 of a 3-beat packet.
        push_pkt(0, 3, 8'h11, 1'b0, 1'b0);
        want.delete();
        drive();
        n = 0;
        while (!(r0_q.size() == 1 && lcd_wr == 1'b0) && n < 50) begin tick(); n++; end
        chk("t6_reached_beat2", 32'(n < 50), 32'd1);
        rst = 1'b1;
        r0_q.delete();
        tick();
        chk("t6_wr", 32'(lcd_wr), 32'd1);
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_data", 32'(lcd_data), 32'd0);
        chk("t6_r0_ready", 32'(r0_ready), 32'd0);
        rst = 1'b0;
        tick();
        mark = cap_q.size();
        push_pkt(1, 2, 8'hC1, 1'b1, 1'b0);
        drive();
        run_idle(100, v0, v1, to);
        chk("t6_timeout", 32'(to), 32'd0);
        cmp_cap("t6", mark);

        // Randomized mix: per-requester order, packet atomicity, strobe timing.
        mark = cap_q.size();
        fm = fall_q.size();
        exp0.delete();
        exp1.delete();
        npk = 0;
        n = 0;
        while ((npk < 24 || r0_q.size() > 0 || r1_q.size() > 0 || busy) && n < 4000) begin
            if (npk < 24 && $urandom_range(0, 9) == 0) begin
                req = $urandom_range(0, 1);
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) begin
                    e = mk(1'($urandom_range(0, 1)), {req[0], 7'($urandom_range(0, 127))},
                           (i == len - 1), (req == 1) && (i == 0) && ($urandom_range(0, 1) == 1));
                    if (req == 0) begin r0_q.push_back(e); exp0.push_back(e); end
                    else          begin r1_q.push_back(e); exp1.push_back(e); end
                end
                npk++;
            end
            p0 = ($urandom_range(0, 3) == 0);
            p1 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) lcd_fmark = ~lcd_fmark;
            tick();
            n++;
        end
        p0 = 1'b0;
        p1 = 1'b0;
        chk("rnd_timeout", 32'(n < 4000), 32'd1);
        chk("rnd_count", 32'(cap_q.size() - mark), 32'(exp0.size() + exp1.size()));
        owner = -1;
        for (int i = mark; i < cap_q.size(); i++) begin
            c = cap_q[i];
            if (owner >= 0) chk("rnd_owner", 32'(c[7]), 32'(owner));
            if (c[7] == 1'b0 && exp0.size() > 0) begin
                e = exp0.pop_front();
                chk("rnd_r0_beat", 32'(c), 32'({e.rs, e.data}));
                owner = e.last ? -1 : 0;
            end else if (c[7] == 1'b1 && exp1.size() > 0) begin
                e = exp1.pop_front();
                chk("rnd_r1_beat", 32'(c), 32'({e.rs, e.data}));
                owner = e.last ? -1 : 1;
            end
        end
        bad = 0;
        for (int i = mark; i < low_q.size(); i++) if (low_q[i] != LOW) bad++;
        chk("rnd_low_width", 32'(bad), 32'd0);
        bad = 0;
        for (int i = fm + 1; i < fall_q.size(); i++)
            if (fall_q[i] - fall_q[i - 1] < LOW + HIGH + 1) bad++;
        chk("rnd_beat_spacing", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
